// File: rtl/mux_share_arbiter.sv
// Round-robin, burst-limited owner of a shared 2:1 select path with a registered output stage.
// Define MUX_SHARE_FIXED_PRIO_EN to give A fixed priority instead.
module mux_share_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [0:WIDTH-1] a,
  input  logic             req_b,
  input  logic [0:WIDTH-1] b,
  input  logic             f_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [0:WIDTH-1] f,
  output logic             f_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] BLIM = 4'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [3:0]       burst_q, burst_d;
  logic [3:0]       burst_inc;
  logic             last_a_q, last_a_d;
  logic             sel_q;
  logic [0:WIDTH-1] f_q;
  logic             fv_q;
  logic             can_load;
  logic             xfer;

  assign can_load  = !fv_q || f_ready;
  assign gnt_a     = (state_q == OWN_A) && req_a && can_load;
  assign gnt_b     = (state_q == OWN_B) && req_b && can_load;
  assign xfer      = gnt_a || gnt_b;
  assign burst_inc = (burst_q == BLIM) ? burst_q : burst_q + 4'd1;

  assign sel     = sel_q;
  assign f       = f_q;
  assign f_valid = fv_q;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    last_a_d = last_a_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
`ifdef MUX_SHARE_FIXED_PRIO_EN
          state_d = OWN_A;
`else
          state_d = last_a_q ? OWN_B : OWN_A;
`endif
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        // A dropped req (done or withdrawn): hand over or idle
        if (!req_a) begin
          state_d  = req_b ? OWN_B : IDLE;
          burst_d  = 4'd0;
          last_a_d = 1'b1;
        end else if (gnt_a) begin
`ifdef MUX_SHARE_FIXED_PRIO_EN
          burst_d = burst_inc;
`else
          if (burst_q == BLIM && req_b) begin
            state_d  = OWN_B;
            burst_d  = 4'd0;
            last_a_d = 1'b1;
          end else begin
            burst_d = burst_inc;
          end
`endif
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d  = req_a ? OWN_A : IDLE;
          burst_d  = 4'd0;
          last_a_d = 1'b0;
        end else if (gnt_b) begin
`ifdef MUX_SHARE_FIXED_PRIO_EN
          if (req_a) begin
            state_d = OWN_A;
            burst_d = 4'd0;
          end else begin
            burst_d = burst_inc;
          end
`else
          if (burst_q == BLIM && req_a) begin
            state_d  = OWN_A;
            burst_d  = 4'd0;
            last_a_d = 1'b0;
          end else begin
            burst_d = burst_inc;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      burst_q  <= 4'd0;
      last_a_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      last_a_q <= last_a_d;
      sel_q    <= (state_d == OWN_A);
    end
  end

  // Load and consume in one cycle keeps fv_q high for full throughput
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q  <= '0;
      fv_q <= 1'b0;
    end else if (xfer) begin
      f_q  <= sel_q ? a : b;
      fv_q <= 1'b1;
    end else if (f_ready) begin
      fv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed plus randomized bench for mux_share_arbiter against a behavioural model.
// Define MUX_SHARE_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_mux_share_arbiter;

  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b, f_ready;
  logic [0:W-1] a, b;
  logic         gnt_a, gnt_b, sel, f_valid;
  logic [0:W-1] f;

  int checks   = 0;
  int failures = 0;

  // model: own 0=idle 1=A 2=B
  int           own, cnt;
  bit           last_a;
  logic [0:W-1] mf;
  bit           mv;
  bit           mga, mgb;
  logic         oga, ogb, osel, ofv;
  logic [0:W-1] of;

  mux_share_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a(a),
    .req_b(req_b), .b(b),
    .f_ready(f_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .sel(sel), .f(f), .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; cnt = 0; last_a = 1'b0; mf = '0; mv = 1'b0;
  endtask

  // Called just after a negedge with inputs already applied
  task automatic step();
    bit ra, rb, rx, ry, tr;
    int x, y;
    #1;
    ra  = req_a; rb = req_b;
    mga = (own == 1) && ra && (!mv || f_ready);
    mgb = (own == 2) && rb && (!mv || f_ready);
    oga = gnt_a; ogb = gnt_b; osel = sel; of = f; ofv = f_valid;
    chk("gnt_a", 32'(gnt_a), 32'(mga));
    chk("gnt_b", 32'(gnt_b), 32'(mgb));
    chk("sel", 32'(sel), 32'(own == 1));
    chk("f_valid", 32'(f_valid), 32'(mv));
    if (mv) chk("f", 32'(f), 32'(mf));
    chk("gnt_excl", 32'(gnt_a && gnt_b), 32'd0);
    tr = mga || mgb;
    if (tr) begin
      mf = mga ? a : b;
      mv = 1'b1;
    end else if (f_ready) begin
      mv = 1'b0;
    end
    if (own == 0) begin
`ifdef MUX_SHARE_FIXED_PRIO_EN
      if (ra) own = 1;
      else if (rb) own = 2;
`else
      if (ra && rb) own = last_a ? 2 : 1;
      else if (ra) own = 1;
      else if (rb) own = 2;
`endif
    end else begin
      x  = own;
      y  = (own == 1) ? 2 : 1;
      rx = (x == 1) ? ra : rb;
      ry = (x == 1) ? rb : ra;
      if (!rx) begin
        own = ry ? y : 0; cnt = 0; last_a = (x == 1);
      end else if (tr) begin
`ifdef MUX_SHARE_FIXED_PRIO_EN
        if (x == 2 && ra) begin own = 1; cnt = 0; end
        else cnt = (cnt + 1 > MAXB - 1) ? MAXB - 1 : cnt + 1;
`else
        if (cnt == MAXB - 1 && ry) begin
          own = y; cnt = 0; last_a = (x == 1);
        end else begin
          cnt = (cnt + 1 > MAXB - 1) ? MAXB - 1 : cnt + 1;
        end
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_a = 0; req_b = 0; f_ready = 0; a = '0; b = '0;
    model_reset();
    #3;
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_fv", 32'(f_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single A, one word per cycle
    req_a = 1; a = 4'b1010; f_ready = 1;
    step();
    chk("a_c0_gnt", 32'(oga), 32'd0);
    step();
    chk("a_c1_gnt", 32'(oga), 32'd1);
    chk("a_c1_sel", 32'(osel), 32'd1);
    step();
    chk("a_c2_f", 32'(of), 32'hA);
    chk("a_c2_fv", 32'(ofv), 32'd1);
    chk("a_c2_gnt", 32'(oga), 32'd1);
    step();

    // back-pressure
    a = 4'b0101; f_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_gnt", 32'(oga), 32'd0);
      chk("bp_f", 32'(of), 32'hA);
    end
    f_ready = 1;
    step();
    chk("bp_rel_gnt", 32'(oga), 32'd1);
    f_ready = 0;
    step();
    chk("bp_rel_f", 32'(of), 32'h5);

    // withdraw while stalled
    req_a = 0; req_b = 1; b = 4'b0011; a = 4'b1111;
    step();
    step();
    chk("wd_sel", 32'(osel), 32'd0);
    chk("wd_f", 32'(of), 32'h5);

    // asynchronous reset mid-cycle with a pending word and a live grant
    req_a = 1; f_ready = 1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_f", 32'(f), 32'd0);
    chk("arst_fv", 32'(f_valid), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // both requesting continuously
    a = 4'b1100; b = 4'b0110; req_a = 1; req_b = 1; f_ready = 1;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef MUX_SHARE_FIXED_PRIO_EN
      chk("fp_gnt_a", 32'(oga), 32'(i >= 1));
      chk("fp_gnt_b", 32'(ogb), 32'd0);
`else
      chk("rr_gnt_a", 32'(oga), 32'((i >= 1 && i <= 4) || i == 9));
      chk("rr_gnt_b", 32'(ogb), 32'(i >= 5 && i <= 8));
`endif
    end

    // randomized protocol-legal traffic
    for (int n = 0; n < 500; n++) begin
      if (req_a) begin
        if (mga) begin
          req_a = ($urandom % 4) != 0; a = W'($urandom);
        end else if ($urandom % 16 == 0) begin
          req_a = 0;
        end
      end else if ($urandom % 3 == 0) begin
        req_a = 1; a = W'($urandom);
      end
      if (req_b) begin
        if (mgb) begin
          req_b = ($urandom % 4) != 0; b = W'($urandom);
        end else if ($urandom % 16 == 0) begin
          req_b = 0;
        end
      end else if ($urandom % 3 == 0) begin
        req_b = 1; b = W'($urandom);
      end
      f_ready = ($urandom % 4) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
